// File: rtl/minn_symbol_framer.sv
// Minn symbol framer: skips START_OFFSET samples after frame_start, then strips CP_LEN and forwards NFFT tagged
// samples per symbol. Build option MINN_FRAMER_RETRIGGER_EN lets a new frame_start abort and restart a frame.
module minn_symbol_framer #(
    parameter int NFFT         = 2048,
    parameter int CP_LEN       = 144,
    parameter int START_OFFSET = 0,
    parameter int NUM_SYMBOLS  = 14,
    parameter int W_IN         = 12,
    parameter int SYM_W        = (NUM_SYMBOLS > 1) ? $clog2(NUM_SYMBOLS) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic signed [W_IN-1:0] in_ch0_i,
    input  logic signed [W_IN-1:0] in_ch0_q,
    input  logic signed [W_IN-1:0] in_ch1_i,
    input  logic signed [W_IN-1:0] in_ch1_q,
    input  logic                   frame_start,
    output logic                   out_valid,
    output logic signed [W_IN-1:0] out_ch0_i,
    output logic signed [W_IN-1:0] out_ch0_q,
    output logic signed [W_IN-1:0] out_ch1_i,
    output logic signed [W_IN-1:0] out_ch1_q,
    output logic                   sym_first,
    output logic                   sym_last,
    output logic [SYM_W-1:0]       sym_index,
    output logic                   frame_done,
    output logic                   busy,
    output logic [7:0]             dropped_starts
);
    localparam int MAX_A   = (NFFT > CP_LEN) ? NFFT : CP_LEN;
    localparam int MAX_LEN = (MAX_A > START_OFFSET) ? MAX_A : START_OFFSET;
    localparam int CNT_W   = $clog2(MAX_LEN + 1);

    localparam logic [CNT_W-1:0] OFF_LAST  = CNT_W'((START_OFFSET > 0) ? START_OFFSET - 1 : 0);
    localparam logic [CNT_W-1:0] CP_LAST   = CNT_W'((CP_LEN > 0) ? CP_LEN - 1 : 0);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(NFFT - 1);
    localparam logic [SYM_W-1:0] SYM_LAST  = SYM_W'(NUM_SYMBOLS - 1);

    typedef enum logic [1:0] {S_IDLE, S_OFFSET, S_CP, S_DATA} state_t;

    function automatic state_t entry_phase();
        if (START_OFFSET > 0) return S_OFFSET;
        if (CP_LEN > 0) return S_CP;
        return S_DATA;
    endfunction

    function automatic state_t symbol_phase();
        if (CP_LEN > 0) return S_CP;
        return S_DATA;
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [SYM_W-1:0] sym_q;

    logic             final_smp;
    logic             restart;
    logic             drop;
    state_t           eff_state;
    logic [CNT_W-1:0] eff_cnt;
    logic [SYM_W-1:0] eff_sym;

    logic                   vld_p0;
    logic                   first_p0;
    logic                   last_p0;
    logic                   done_p0;
    logic                   busy_p0;
    logic [SYM_W-1:0]       sym_p0;
    logic [7:0]             drop_p0;
    logic signed [W_IN-1:0] ch0_i_p0;
    logic signed [W_IN-1:0] ch0_q_p0;
    logic signed [W_IN-1:0] ch1_i_p0;
    logic signed [W_IN-1:0] ch1_q_p0;

    // An accepted start makes the current sample behave as sample 0 of the entry phase.
    always_comb begin
        final_smp = (state == S_DATA) && (cnt == DATA_LAST) && (sym_q == SYM_LAST);
`ifdef MINN_FRAMER_RETRIGGER_EN
        restart   = in_valid && frame_start && !final_smp;
`else
        restart   = in_valid && frame_start && (state == S_IDLE);
`endif
        drop      = in_valid && frame_start && (state != S_IDLE);
        eff_state = restart ? entry_phase() : state;
        eff_cnt   = restart ? '0 : cnt;
        eff_sym   = restart ? '0 : sym_q;
    end

    // Stage p0: phase sequencing and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            sym_q    <= '0;
            vld_p0   <= 1'b0;
            first_p0 <= 1'b0;
            last_p0  <= 1'b0;
            done_p0  <= 1'b0;
            busy_p0  <= 1'b0;
            sym_p0   <= '0;
            drop_p0  <= '0;
            ch0_i_p0 <= '0;
            ch0_q_p0 <= '0;
            ch1_i_p0 <= '0;
            ch1_q_p0 <= '0;
        end else begin
            vld_p0   <= 1'b0;
            first_p0 <= 1'b0;
            last_p0  <= 1'b0;
            done_p0  <= 1'b0;
            busy_p0  <= (eff_state != S_IDLE);
            if (drop) drop_p0 <= sat_inc(drop_p0);
            if (in_valid) begin
                state <= eff_state;
                cnt   <= eff_cnt + CNT_W'(1);
                sym_q <= eff_sym;
                case (eff_state)
                    S_IDLE: cnt <= '0;
                    S_OFFSET: begin
                        if (eff_cnt == OFF_LAST) begin
                            state <= symbol_phase();
                            cnt   <= '0;
                        end
                    end
                    S_CP: begin
                        if (eff_cnt == CP_LAST) begin
                            state <= S_DATA;
                            cnt   <= '0;
                        end
                    end
                    S_DATA: begin
                        vld_p0   <= 1'b1;
                        ch0_i_p0 <= in_ch0_i;
                        ch0_q_p0 <= in_ch0_q;
                        ch1_i_p0 <= in_ch1_i;
                        ch1_q_p0 <= in_ch1_q;
                        first_p0 <= (eff_cnt == '0);
                        last_p0  <= (eff_cnt == DATA_LAST);
                        sym_p0   <= eff_sym;
                        if (eff_cnt == DATA_LAST) begin
                            cnt <= '0;
                            if (eff_sym == SYM_LAST) begin
                                state   <= S_IDLE;
                                sym_q   <= '0;
                                done_p0 <= 1'b1;
                            end else begin
                                state <= symbol_phase();
                                sym_q <= eff_sym + SYM_W'(1);
                            end
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign out_valid      = vld_p0;
    assign out_ch0_i      = ch0_i_p0;
    assign out_ch0_q      = ch0_q_p0;
    assign out_ch1_i      = ch1_i_p0;
    assign out_ch1_q      = ch1_q_p0;
    assign sym_first      = first_p0;
    assign sym_last       = last_p0;
    assign sym_index      = sym_p0;
    assign frame_done     = done_p0;
    assign busy           = busy_p0;
    assign dropped_starts = drop_p0;

endmodule
